idu: RTL and testbench
======================

IDU -- requirements
Module: idu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving data/PC width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ifu_valid  input  1  upstream fetch packet valid.
REQ-005 SHALL have port ifu_data  input  64  fetch packet, [63:32] instruction, [31:0] PC.
REQ-006 SHALL have port idu_ready  output  1  decode stage can accept a packet this cycle.
REQ-007 SHALL have port idu_valid  output  1  decoded bundle valid to EXU.
REQ-008 SHALL have port exu_ready  input  1  downstream accepts bundle.
REQ-009 SHALL have outputs pc/inst/imm (WIDTH each), rs1/rs2/rd (5 each), rd_wen (1), fu_type (fu_type_t), alu_op (alu_op_t) and illegal (1), all registered.

Function
REQ-010 SHALL hold one-entry output register with FSM states S_EMPTY, S_FULL.
REQ-011 SHALL drive idu_ready = (state==S_EMPTY) | exu_ready, combinationally.
REQ-012 SHALL accept on ifu_valid & idu_ready; decoded bundle appears with idu_valid=1 the next cycle (latency 1).
REQ-013 SHALL transition S_EMPTY->S_FULL on accept; S_FULL->S_EMPTY on exu_ready & !ifu_valid; remain S_FULL on simultaneous drain and accept, reloading the register.
REQ-014 SHALL keep all bundle outputs stable while idu_valid & !exu_ready.
REQ-015 SHALL drive idu_valid = (state==S_FULL).
REQ-016 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM(ECALL/EBREAK) into fu_type {ALU, BRU, LSU, CSR}.
REQ-017 SHALL sign-extend I/S/B/J immediates and form U immediate as inst[31:12]<<12; B/J imm bit0 = 0.
REQ-018 SHALL set rd_wen=0 for BRANCH, STORE, SYSTEM and whenever rd==0.
REQ-019 SHALL set illegal=1, rd_wen=0, for unknown opcode or unsupported funct3/funct7 combination; bundle still valid.
REQ-020 SHALL zero rs2 for formats without rs2 and rs1 for U/J formats.

Reset
REQ-021 SHALL, while rst=0, force state S_EMPTY and all registered outputs to 0 asynchronously.
REQ-022 SHALL discard any held bundle on reset mid-operation; idu_ready=1 first cycle after release.

Configuration
REQ-023 SHALL honour macro IDU_RV32E_EN: defined -> any rs1/rs2/rd index >=16 sets illegal=1; undefined -> full 32-register RV32I, no such check.

Structure
REQ-024 SHALL place fu_type_t, alu_op_t, opcode localparams and the state enum in shared package npc_pkg.
REQ-025 SHALL implement immediate generation in sub-module imm_gen (combinational, inst -> imm).

Verification
REQ-026 SHALL test accept: ifu_data={0x00500093,0x80000000}, exu_ready=1 -> next cycle idu_valid=1, rd=1, rs1=0, imm=5, fu_type=ALU, rd_wen=1.
REQ-027 SHALL test backpressure: exu_ready=0 with bundle held 5 cycles -> idu_ready=0, outputs unchanged; exu_ready=1 -> drain, idu_ready=1.
REQ-028 SHALL test immediates: 0x123450B7 -> imm=0x12345000; 0xFE000EE3 -> imm=0xFFFFFFFC, rd_wen=0, fu_type=BRU.
REQ-029 SHALL test illegal: inst 0x00000000 -> illegal=1, rd_wen=0, idu_valid=1.
REQ-030 SHALL test macro: inst 0x00000833 (add x16) -> illegal=1 with IDU_RV32E_EN, illegal=0/rd=16 without.
REQ-031 SHALL test back-to-back packets with continuous exu_ready=1 -> one bundle per cycle, none lost; rst low mid-stream -> idu_valid=0 immediately.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared decode types for the NPC pipeline: opcodes, functional-unit and ALU
// operation encodings, the decode-stage state enum and the decoded bundle.
package npc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_LSU = 2'd2,
    FU_CSR = 2'd3
  } fu_type_t;

  // ALU_LUI passes the immediate straight through; branches reuse the
  // compare ops (SUB for eq/ne, SLT/SLTU for signed/unsigned ordering).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } idu_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_wen;
    fu_type_t          fu_type;
    alu_op_t           alu_op;
    logic              illegal;
  } idu_bundle_t;

  // Integer ALU op from funct3; alt selects SUB/SRA when funct7[5] is set.
  function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: combinational RV32I immediate extraction by opcode.
module imm_gen
  import npc_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  // Select I/S/B/U/J immediate format from the opcode; R-type and unknown give 0.
  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/idu.sv
// Instruction decode unit: one-entry registered decode stage between IFU and EXU.
// Build option: define IDU_RV32E_EN to flag any register index >= 16 as illegal
// (RV32E register file); leave it undefined for the full 32-register RV32I file.
module idu
  import npc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_valid,
  input  logic [63:0]      ifu_data,
  output logic             idu_ready,
  output logic             idu_valid,
  input  logic             exu_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             rd_wen,
  output fu_type_t         fu_type,
  output alu_op_t          alu_op,
  output logic             illegal
);

`ifdef IDU_RV32E_EN
  localparam bit RV32E = 1'b1;
`else
  localparam bit RV32E = 1'b0;
`endif

  idu_state_t        state_q;
  idu_state_t        state_d;
  logic              accept;
  logic [XLEN-1:0]   f_inst;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [XLEN-1:0]   dec_imm;
  idu_bundle_t       dec;
  idu_bundle_t       bnd_q;
  logic              legal;
  logic              has_rs1;
  logic              has_rs2;
  logic              has_rd;
  logic              wr_rd;

  assign f_inst = ifu_data[63:32];
  assign opc    = f_inst[6:0];
  assign f3     = f_inst[14:12];
  assign f7     = f_inst[31:25];

  assign idu_ready = (state_q == S_EMPTY) | exu_ready;
  assign idu_valid = (state_q == S_FULL);
  assign accept    = ifu_valid & idu_ready;

  imm_gen u_imm_gen (
    .inst (f_inst),
    .imm  (dec_imm)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  // Next state: fill on accept, empty only when drained with nothing new arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (ifu_valid)               state_d = S_FULL;
      S_FULL:  if (exu_ready && !ifu_valid) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Decode the incoming instruction into register fields, unit, op and legality.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    has_rs1 = 1'b0;
    has_rs2 = 1'b0;
    has_rd  = 1'b0;
    wr_rd   = 1'b0;
    case (opc)
      OPC_LUI: begin
        has_rd = 1'b1; wr_rd = 1'b1; legal = 1'b1;
        dec.alu_op = ALU_LUI;
      end
      OPC_AUIPC: begin
        has_rd = 1'b1; wr_rd = 1'b1; legal = 1'b1;
      end
      OPC_JAL: begin
        has_rd = 1'b1; wr_rd = 1'b1; legal = 1'b1;
        dec.fu_type = FU_BRU;
      end
      OPC_JALR: begin
        has_rs1 = 1'b1; has_rd = 1'b1; wr_rd = 1'b1;
        legal = (f3 == 3'b000);
        dec.fu_type = FU_BRU;
      end
      OPC_BRANCH: begin
        has_rs1 = 1'b1; has_rs2 = 1'b1;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        dec.fu_type = FU_BRU;
        dec.alu_op  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OPC_LOAD: begin
        has_rs1 = 1'b1; has_rd = 1'b1; wr_rd = 1'b1;
        legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        dec.fu_type = FU_LSU;
      end
      OPC_STORE: begin
        has_rs1 = 1'b1; has_rs2 = 1'b1;
        legal = !f3[2] && (f3[1:0] != 2'b11);
        dec.fu_type = FU_LSU;
      end
      OPC_OP_IMM: begin
        has_rs1 = 1'b1; has_rd = 1'b1; wr_rd = 1'b1;
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
        dec.alu_op = alu_op_of(f3, (f3 == 3'b101) && f_inst[30]);
      end
      OPC_OP: begin
        has_rs1 = 1'b1; has_rs2 = 1'b1; has_rd = 1'b1; wr_rd = 1'b1;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alu_op = alu_op_of(f3, f_inst[30]);
      end
      OPC_SYSTEM: begin
        has_rs1 = 1'b1; has_rd = 1'b1;
        legal = (f_inst == INST_ECALL) || (f_inst == INST_EBREAK);
        dec.fu_type = FU_CSR;
      end
      default: legal = 1'b0;
    endcase

    dec.rs1 = has_rs1 ? f_inst[19:15] : 5'd0;
    dec.rs2 = has_rs2 ? f_inst[24:20] : 5'd0;
    dec.rd  = has_rd  ? f_inst[11:7]  : 5'd0;

    // RV32E only provides x0..x15.
    if (RV32E && (dec.rs1[4] || dec.rs2[4] || dec.rd[4])) legal = 1'b0;

    dec.illegal = !legal;
    dec.rd_wen  = wr_rd && legal && (dec.rd != 5'd0);
  end

  // Output register: reload on every accepted packet, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      inst  <= '0;
      imm   <= '0;
      bnd_q <= '0;
    end else if (accept) begin
      pc    <= WIDTH'(ifu_data[31:0]);
      inst  <= WIDTH'(f_inst);
      imm   <= WIDTH'(dec_imm);
      bnd_q <= dec;
    end
  end

  assign rs1     = bnd_q.rs1;
  assign rs2     = bnd_q.rs2;
  assign rd      = bnd_q.rd;
  assign rd_wen  = bnd_q.rd_wen;
  assign fu_type = bnd_q.fu_type;
  assign alu_op  = bnd_q.alu_op;
  assign illegal = bnd_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Testbench for idu: directed vector table, hand sequences for backpressure
// and reset, then randomized traffic against a behavioural decode model.
module tb_idu;
  import npc_pkg::*;

`ifdef IDU_RV32E_EN
  localparam bit E_MODE = 1'b1;
`else
  localparam bit E_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [63:0] ifu_data = '0;
  logic        exu_ready = 1'b0;
  logic        idu_ready, idu_valid;
  logic [31:0] pc, inst, imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_wen, illegal;
  fu_type_t    fu_type;
  alu_op_t     alu_op;

  idu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_data(ifu_data),
    .idu_ready(idu_ready), .idu_valid(idu_valid), .exu_ready(exu_ready),
    .pc(pc), .inst(inst), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rd_wen(rd_wen), .fu_type(fu_type), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of the one-entry stage: is a bundle held, and which packet.
  bit          m_full = 1'b0;
  logic [63:0] m_pkt = '0;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    bit          wen, ill, alu_chk;
    fu_type_t    fu;
    alu_op_t     alu;
  } exp_t;

  typedef struct {
    logic [31:0] inst, imm;
    logic [4:0]  rd, rs1, rs2;
    fu_type_t    fu;
    bit          wen, ill;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h want=0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the ISA description in arithmetic form.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int sgn;
    bit writes, ok, u1, u2, ud;
    alu_op_t by_f3 [8];
    by_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    sgn = i[31] ? -1 : 0;
    writes = 0; ok = 0; u1 = 0; u2 = 0; ud = 0;
    e.imm = '0; e.fu = FU_ALU; e.alu = ALU_ADD;
    if (op == OPC_LUI || op == OPC_AUIPC) begin
      ud = 1; writes = 1; ok = 1;
      e.imm = i & 32'hFFFF_F000;
      if (op == OPC_LUI) e.alu = ALU_LUI;
    end else if (op == OPC_JAL) begin
      ud = 1; writes = 1; ok = 1; e.fu = FU_BRU;
      e.imm = 32'(sgn * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
    end else if (op == OPC_BRANCH) begin
      u1 = 1; u2 = 1; e.fu = FU_BRU;
      ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      e.alu = (f3 inside {3'd0, 3'd1}) ? ALU_SUB : (f3 inside {3'd4, 3'd5}) ? ALU_SLT : ALU_SLTU;
      e.imm = 32'(sgn * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
    end else if (op == OPC_STORE) begin
      u1 = 1; u2 = 1; e.fu = FU_LSU;
      ok = f3 inside {3'd0, 3'd1, 3'd2};
      e.imm = 32'(($signed(i) >>> 25) * 32 + int'(i[11:7]));
    end else if (op inside {OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM}) begin
      u1 = 1; ud = 1;
      e.imm = 32'($signed(i) >>> 20);
      if (op == OPC_JALR) begin
        writes = 1; ok = (f3 == 3'd0); e.fu = FU_BRU;
      end else if (op == OPC_LOAD) begin
        writes = 1; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.fu = FU_LSU;
      end else if (op == OPC_OP_IMM) begin
        writes = 1;
        ok = !(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : by_f3[f3];
      end else begin
        ok = (i == 32'h0000_0073) || (i == 32'h0010_0073); e.fu = FU_CSR;
      end
    end else if (op == OPC_OP) begin
      u1 = 1; u2 = 1; ud = 1; writes = 1;
      ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      e.alu = (f7 == 7'h20 && f3 == 3'd0) ? ALU_SUB : (f7 == 7'h20 && f3 == 3'd5) ? ALU_SRA : by_f3[f3];
    end
    e.rs1 = u1 ? i[19:15] : 5'd0;
    e.rs2 = u2 ? i[24:20] : 5'd0;
    e.rd  = ud ? i[11:7]  : 5'd0;
    if (E_MODE && (e.rs1 >= 16 || e.rs2 >= 16 || e.rd >= 16)) ok = 0;
    e.ill = !ok;
    e.wen = writes && ok && (e.rd != 0);
    e.alu_chk = ok;
    return e;
  endfunction

  // Compare every bundle output against the model's held packet.
  task automatic check_out();
    exp_t e;
    chk("idu_valid", 32'(idu_valid), 32'(m_full));
    if (m_full) begin
      e = ref_decode(m_pkt[63:32]);
      chk("pc", pc, m_pkt[31:0]);
      chk("inst", inst, m_pkt[63:32]);
      chk("imm", imm, e.imm);
      chk("rs1", 32'(rs1), 32'(e.rs1));
      chk("rs2", 32'(rs2), 32'(e.rs2));
      chk("rd", 32'(rd), 32'(e.rd));
      chk("rd_wen", 32'(rd_wen), 32'(e.wen));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("fu_type", 32'(fu_type), 32'(e.fu));
      if (e.alu_chk) chk("alu_op", 32'(alu_op), 32'(e.alu));
    end
  endtask

  // One clock: drive at negedge, check ready, then update model and check outputs.
  task automatic step(input bit v, input logic [63:0] d, input bit er);
    bit acc;
    @(negedge clk);
    ifu_valid = v; ifu_data = d; exu_ready = er;
    #1;
    chk("idu_ready", 32'(idu_ready), 32'(!m_full || er));
    acc = v && (!m_full || er);
    @(posedge clk);
    #1;
    if (acc) begin
      m_full = 1'b1; m_pkt = d;
    end else if (er) begin
      m_full = 1'b0;
    end
    check_out();
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0] ops [10];
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM};
    r = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: r = ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
      default: begin
        r[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 1) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
    endcase
    return r;
  endfunction

  vec_t vt [12];
  int   seen;

  initial begin
    vt[0]  = '{32'h0050_0093, 32'h0000_0005, 5'd1,  5'd0, 5'd0, FU_ALU, 1'b1, 1'b0};
    vt[1]  = '{32'h1234_50B7, 32'h1234_5000, 5'd1,  5'd0, 5'd0, FU_ALU, 1'b1, 1'b0};
    vt[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 5'd0,  5'd0, 5'd0, FU_BRU, 1'b0, 1'b0};
    vt[3]  = '{32'h0000_0000, 32'h0000_0000, 5'd0,  5'd0, 5'd0, FU_ALU, 1'b0, 1'b1};
    vt[4]  = '{32'h0000_0833, 32'h0000_0000, 5'd16, 5'd0, 5'd0, FU_ALU, !E_MODE, E_MODE};
    vt[5]  = '{32'h0000_0073, 32'h0000_0000, 5'd0,  5'd0, 5'd0, FU_CSR, 1'b0, 1'b0};
    vt[6]  = '{32'h0080_00EF, 32'h0000_0008, 5'd1,  5'd0, 5'd0, FU_BRU, 1'b1, 1'b0};
    vt[7]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 5'd0,  5'd1, 5'd2, FU_LSU, 1'b0, 1'b0};
    vt[8]  = '{32'h0101_A283, 32'h0000_0010, 5'd5,  5'd3, 5'd0, FU_LSU, 1'b1, 1'b0};
    vt[9]  = '{32'h4020_81B3, 32'h0000_0000, 5'd3,  5'd1, 5'd2, FU_ALU, 1'b1, 1'b0};
    vt[10] = '{32'h4020_C1B3, 32'h0000_0000, 5'd3,  5'd1, 5'd2, FU_ALU, 1'b0, 1'b1};
    vt[11] = '{32'hFFFF_F517, 32'hFFFF_F000, 5'd10, 5'd0, 5'd0, FU_ALU, 1'b1, 1'b0};

    // Reset state while rst is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idu_valid", 32'(idu_valid), 32'd0);
    chk("rst_idu_ready", 32'(idu_ready), 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_rd_wen", 32'(rd_wen), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed decode vectors, streamed back to back with exu_ready high.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, {vt[k].inst, 32'h8000_0000 + 32'(k * 4)}, 1'b1);
      chk($sformatf("vec%0d_valid", k), 32'(idu_valid), 32'd1);
      chk($sformatf("vec%0d_imm", k), imm, vt[k].imm);
      chk($sformatf("vec%0d_rd", k), 32'(rd), 32'(vt[k].rd));
      chk($sformatf("vec%0d_rs1", k), 32'(rs1), 32'(vt[k].rs1));
      chk($sformatf("vec%0d_rs2", k), 32'(rs2), 32'(vt[k].rs2));
      chk($sformatf("vec%0d_fu", k), 32'(fu_type), 32'(vt[k].fu));
      chk($sformatf("vec%0d_wen", k), 32'(rd_wen), 32'(vt[k].wen));
      chk($sformatf("vec%0d_ill", k), 32'(illegal), 32'(vt[k].ill));
    end
    step(1'b0, '0, 1'b1);

    // Backpressure: hold a bundle for 5 cycles while another packet is offered.
    step(1'b1, {32'h0050_0093, 32'h8000_0000}, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, {32'h1234_50B7, 32'h9000_0000}, 1'b0);
      chk("bp_idu_ready", 32'(idu_ready), 32'd0);
      chk("bp_pc_held", pc, 32'h8000_0000);
      chk("bp_imm_held", imm, 32'd5);
    end
    step(1'b0, '0, 1'b1);
    chk("bp_drained_valid", 32'(idu_valid), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("bp_empty_ready", 32'(idu_ready), 32'd1);

    // Back-to-back stream: one bundle per cycle, in order.
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, {32'h0010_0113 + 32'(k << 20), 32'hA000_0000 + 32'(k * 4)}, 1'b1);
      if (idu_valid && pc == 32'hA000_0000 + 32'(k * 4)) seen++;
    end
    chk("b2b_bundles", 32'(seen), 32'd8);

    // Reset mid-stream: the held bundle vanishes immediately.
    @(negedge clk);
    rst = 1'b0; ifu_valid = 1'b0; exu_ready = 1'b0;
    #1;
    chk("midrst_valid", 32'(idu_valid), 32'd0);
    chk("midrst_pc", pc, 32'd0);
    m_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    chk("post_rst_ready", 32'(idu_ready), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, {gen_inst(), 32'($urandom)}, $urandom_range(0, 3) != 0);
    end
    step(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
